// File: rtl/prbs7_checker_pkg.sv
// Shared PRBS7 definitions: widths, state recurrence and checker state encoding.
package prbs7_checker_pkg;

    localparam int unsigned PRBS_W = 7;
    localparam int unsigned WORD_W = 8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // x^7 + x^6 + 1 shift, period 127
    function automatic logic [PRBS_W-1:0] prbs7_next(input logic [PRBS_W-1:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/prbs7_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module prbs7_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 word checker: self-synchronises to the incoming stream, flags bad
// words and keeps saturating error/word counters while locked.
module prbs7_checker
    import prbs7_checker_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned LOSS_WINDOW = 16,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_counts,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] word_count
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WIN_W   = $clog2(LOSS_WINDOW + 1);

    state_t              state;
    logic [MATCH_W-1:0]  match_cnt;
    logic                have_prev;
    logic [PRBS_W-1:0]   prev;
    logic [PRBS_W-1:0]   ref_state;
    logic [WIN_W-1:0]    win_cnt;
    logic [WIN_W-1:0]    win_err;

    logic [PRBS_W-1:0]   in_state_c;
    logic                word_ok_c;
    logic                search_match_c;
    logic [MATCH_W-1:0]  match_nxt_c;
    logic [WORD_W-1:0]   expect_word_c;
    logic                lock_err_c;
    logic [WIN_W-1:0]    win_cnt_nxt_c;
    logic [WIN_W-1:0]    win_err_nxt_c;
    logic                word_inc_c;
    logic                err_inc_c;

    // Per-word comparison terms for both states
    always_comb begin
        in_state_c     = in_data[PRBS_W-1:0];
        word_ok_c      = (in_data[7] == in_data[6]);
        search_match_c = have_prev && word_ok_c && (in_state_c != '0)
                         && (in_state_c == prbs7_next(prev));
        match_nxt_c    = search_match_c ? match_cnt + MATCH_W'(1) : '0;
        expect_word_c  = {ref_state[PRBS_W-1], ref_state};
        lock_err_c     = (in_data != expect_word_c);
        win_cnt_nxt_c  = win_cnt + WIN_W'(1);
        win_err_nxt_c  = win_err + WIN_W'(lock_err_c);
        word_inc_c     = in_valid && (state == LOCKED);
        err_inc_c      = word_inc_c && lock_err_c;
    end

    // Lock state machine; ref_state free-runs once locked so one bad bit costs one word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            match_cnt <= '0;
            have_prev <= 1'b0;
            prev      <= '0;
            ref_state <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        prev      <= in_state_c;
                        have_prev <= 1'b1;
                        if (match_nxt_c == MATCH_W'(LOCK_COUNT)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            ref_state <= prbs7_next(in_state_c);
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_nxt_c;
                        end
                    end
                    LOCKED: begin
                        ref_state <= prbs7_next(ref_state);
                        err_pulse <= lock_err_c;
                        if (win_err_nxt_c == WIN_W'(LOSS_THRESH)) begin
                            state     <= SEARCH;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            have_prev <= 1'b0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else if (win_cnt_nxt_c == WIN_W'(LOSS_WINDOW)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt_nxt_c;
                            win_err <= win_err_nxt_c;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    prbs7_sat_counter #(.WIDTH(16)) u_err_count (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_counts),
        .inc   (err_inc_c),
        .count (err_count)
    );

    prbs7_sat_counter #(.WIDTH(32)) u_word_count (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_counts),
        .inc   (word_inc_c),
        .count (word_count)
    );

endmodule

// File: tb/tb_prbs7_checker.sv
// Scoreboard bench for prbs7_checker: a sequence-table reference model predicts
// every cycle's outputs; a separate monitor compares them after each clock edge.
module tb_prbs7_checker;

    localparam int LOCK_COUNT  = 8;
    localparam int LOSS_WINDOW = 16;
    localparam int LOSS_THRESH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr_counts = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] word_count;

    always #5 clk = ~clk;

    prbs7_checker dut (
        .clk        (clk),
        .reset      (reset),
        .clr_counts (clr_counts),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .word_count (word_count)
    );

    typedef struct packed {
        logic        lk;
        logic        pulse;
        logic [15:0] ec;
        logic [31:0] wc;
    } obs_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t sb_q[$];

    // Reference model state
    bit [6:0] seq [127];
    int       pos;
    bit       m_locked;
    int       m_cnt;
    bit [6:0] m_prev;
    bit       m_have;
    bit [6:0] m_ref;
    int       win_q[$];
    longint   m_ec;
    longint   m_wc;

    function automatic obs_t cur();
        return {locked, err_pulse, err_count, word_count};
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got locked=%b pulse=%b err=%0d words=%0d, expected locked=%b pulse=%b err=%0d words=%0d",
                     name, $time, act.lk, act.pulse, act.ec, act.wc, exp.lk, exp.pulse, exp.ec, exp.wc);
        end
    endtask

    task automatic chk(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Successor found by position in the maximal-length sequence; zero maps to zero
    function automatic bit [6:0] succ(bit [6:0] s);
        for (int i = 0; i < 127; i++)
            if (seq[i] == s) return seq[(i + 1) % 127];
        return 7'h00;
    endfunction

    function automatic bit [7:0] src_word();
        bit [7:0] w;
        w   = {seq[pos][6], seq[pos]};
        pos = (pos + 1) % 127;
        return w;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_cnt = 0; m_prev = 0; m_have = 0; m_ref = 0;
        win_q.delete(); m_ec = 0; m_wc = 0;
    endtask

    task automatic model(bit v, bit [7:0] d, bit clr, output obs_t e);
        bit ok;
        bit err;
        err = 0;
        if (v) begin
            if (!m_locked) begin
                ok = m_have && (d[7] == d[6]) && (d[6:0] != 0) && (d[6:0] == succ(m_prev));
                m_cnt  = ok ? m_cnt + 1 : 0;
                m_prev = d[6:0];
                m_have = 1;
                if (m_cnt == LOCK_COUNT) begin
                    m_locked = 1; m_cnt = 0; m_ref = succ(d[6:0]); win_q.delete();
                end
            end else begin
                err   = (d != {m_ref[6], m_ref});
                m_ref = succ(m_ref);
                if (m_wc < 64'hFFFF_FFFF) m_wc++;
                if (err && m_ec < 16'hFFFF) m_ec++;
                win_q.push_back(int'(err));
                if (win_q.sum() == LOSS_THRESH) begin
                    m_locked = 0; m_cnt = 0; m_have = 0; win_q.delete();
                end else if (win_q.size() == LOSS_WINDOW) begin
                    win_q.delete();
                end
            end
        end
        if (clr) begin
            m_ec = 0; m_wc = 0;
        end
        e = {m_locked, err, 16'(m_ec), 32'(m_wc)};
    endtask

    // Drive one cycle of inputs and queue the response expected after the next edge
    task automatic step(bit v, bit [7:0] d, bit clr);
        obs_t e;
        @(posedge clk);
        #2;
        in_valid = v; in_data = d; clr_counts = clr;
        model(v, d, clr, e);
        sb_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 8'($urandom), 0);
    endtask

    task automatic send_clean(int n, bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) step(0, 8'($urandom), 0);
            step(1, src_word(), 0);
        end
    endtask

    task automatic send_bad(bit [7:0] mask);
        step(1, src_word() ^ mask, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1; in_valid = 0; clr_counts = 0;
        #1;
        check("async_reset", cur(), '0);
        model_reset();
        sb_q.push_back('0);
        @(posedge clk);
        #2;
        reset = 0;
    endtask

    // Monitor: compare each queued expectation just after the edge it refers to
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("scoreboard", cur(), e);
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        bit [6:0] s;
        bit       v;
        bit       clr;
        bit [7:0] mask;
        int       rate;

        s = 7'h01;
        for (int i = 0; i < 127; i++) begin
            seq[i] = s;
            s = {s[5:0], s[6] ^ s[5]};
        end

        #1 reset = 1;
        #3 check("reset_init", cur(), '0);
        model_reset();
        @(posedge clk);
        #2 reset = 0;

        // Lock from seed 01: first word primes, eight matches lock
        pos = 0;
        send_clean(8, 0);
        idle();
        chk("lock_after_8", longint'(locked), 0);
        send_clean(1, 0);
        idle();
        chk("lock_after_9", longint'(locked), 1);
        chk("lock_err0", longint'(err_count), 0);

        // Single bit error
        send_clean(5, 0);
        send_bad(8'h04);
        idle();
        chk("single_pulse", longint'(err_pulse), 1);
        chk("single_count", longint'(err_count), 1);
        chk("single_locked", longint'(locked), 1);
        idle();
        chk("single_pulse_off", longint'(err_pulse), 0);
        send_clean(20, 0);
        idle();
        chk("single_no_more", longint'(err_count), 1);

        // Loss of lock: 4 bad words inside one window
        step(0, 8'h00, 1);
        send_bad(8'h10); send_clean(1, 0); send_bad(8'h01);
        idle();
        chk("loss_hold_2", longint'(locked), 1);
        send_bad(8'h20);
        idle();
        chk("loss_hold_3", longint'(locked), 1);
        send_clean(1, 0); send_bad(8'h02);
        idle();
        chk("loss_unlock", longint'(locked), 0);
        chk("loss_errs", longint'(err_count), 4);
        send_clean(9, 0);
        idle();
        chk("relock", longint'(locked), 1);
        chk("relock_errs", longint'(err_count), 4);

        // Stuck-at-zero source, then a bit7/bit6 violation in search
        do_reset();
        for (int i = 0; i < 30; i++) step(1, 8'h00, 0);
        idle();
        chk("zero_unlocked", longint'(locked), 0);
        chk("zero_errs", longint'(err_count), 0);
        pos = 10;
        send_clean(5, 0);
        step(1, 8'h40, 0);
        send_clean(8, 0);
        idle();
        chk("bad40_unlocked", longint'(locked), 0);
        send_clean(1, 0);
        idle();
        chk("bad40_relock", longint'(locked), 1);

        // Gaps and clear-beats-increment
        step(0, 8'h00, 1);
        send_clean(20, 1);
        idle();
        chk("gap_words", longint'(word_count), 20);
        step(1, src_word() ^ 8'h04, 1);
        idle();
        chk("clr_pulse", longint'(err_pulse), 1);
        chk("clr_errs", longint'(err_count), 0);
        chk("clr_words", longint'(word_count), 0);

        // Reset mid-stream with err_count=5
        for (int k = 0; k < 5; k++) begin
            send_bad(8'h08);
            send_clean(7, 0);
        end
        idle();
        chk("pre_reset_errs", longint'(err_count), 5);
        chk("pre_reset_locked", longint'(locked), 1);
        do_reset();
        send_clean(9, 0);
        idle();
        chk("post_reset_lock", longint'(locked), 1);
        chk("post_reset_words", longint'(word_count), 0);
        send_clean(3, 0);
        idle();
        chk("post_reset_count", longint'(word_count), 3);

        // Randomized traffic alternating light and heavy error rates
        for (int i = 0; i < 3000; i++) begin
            rate = ((i / 400) % 2 == 1) ? 4 : 40;
            v    = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 99) == 0);
            if (!v) begin
                step(0, 8'($urandom), clr);
            end else begin
                mask = 8'h00;
                if ($urandom_range(0, rate - 1) == 0) mask = 8'($urandom_range(1, 255));
                step(1, src_word() ^ mask, clr);
            end
        end

        idle();
        idle();
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Downstream consumer of the 8-bit PRBS7 word generator. Self-synchronises to the incoming word stream, flags mismatching words and keeps saturating error and word counters for BER measurement on the test path.
- Incoming word format: bits [6:0] are the generator state and bit 7 duplicates bit 6.
- State recurrence: next(s) = {s[5:0], s[6]^s[5]} (x^7+x^6+1, period 127).

Parameters:
- LOCK_COUNT, 8: consecutive self-consistent words required to declare lock.
- LOSS_WINDOW, 16: length, in valid words, of the loss-of-lock observation window.
- LOSS_THRESH, 4: errors within one window that force a return to search. Must be ≤ LOSS_WINDOW.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- clr_counts, input, 1: synchronous clear of err_count and word_count.
- in_valid, input, 1: in_data holds a new PRBS word this cycle.
- in_data, input, 8: received word.
- locked, output, 1: checker is in the LOCKED state.
- err_pulse, output, 1: one-cycle flag for a mismatching word.
- err_count, output, 16: saturating count of mismatched words while locked.
- word_count, output, 32: saturating count of valid words checked while locked.

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high. Every register clears: locked=0, err_pulse=0, err_count=0, word_count=0, state=SEARCH, match_cnt=0, have_prev=0, win_cnt=0, win_err=0. Reset mid-stream discards all lock history.
- All outputs are registered. Response appears the cycle after the in_valid cycle it concerns. Cycles with in_valid=0 change nothing except clr_counts.
- Word consistency: in_data[7]==in_data[6] is required. A violation counts as a mismatch in every state.
- SEARCH state:
  - On a valid word d, it is a match when have_prev=1, d[6:0]==next(prev), d[7]==d[6] and d[6:0]!=0.
  - On a match: match_cnt+1.
  - Otherwise: match_cnt=0.
  - In both cases prev<=d[6:0] and have_prev<=1.
  - The all-zero lock-up word never matches, so the checker cannot lock on a stuck-at-zero source.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED, ref<=next(d[6:0]), win_cnt=0, win_err=0. locked rises the next cycle.
  - No errors are counted in SEARCH.
- LOCKED state:
  - Each valid word is compared with ref, including the bit-7 check. ref<=next(ref) on every valid word regardless of the result. The received data is never reloaded into ref, so a single bit error produces exactly one error word.
  - Every valid word: word_count+1, saturating at 2^32-1.
  - Mismatch: err_pulse=1 for one cycle, err_count+1 (saturating at 16'hFFFF), win_err+1.
  - win_cnt counts valid words. When it reaches LOSS_WINDOW, win_cnt and win_err reset to 0. The current word's error is counted before this reset.
  - When win_err reaches LOSS_THRESH: go to SEARCH with match_cnt=0 and have_prev=0. locked falls the next cycle. Counters hold their values.
- clr_counts beats a same-cycle increment: both counters become 0 and that word is not counted. err_pulse still fires.
- Counters freeze at saturation; they never wrap.

Decomposition:
- Shared package: PRBS7 width constant (7), word width (8), the next-state function prbs7_next, and the state enum {SEARCH, LOCKED}.
- One natural sub-module: prbs7_sat_counter (parameterised width, inc, clr, saturate). Instantiated for err_count and word_count.

Test Plan:
- Reference sequence from seed 7'h01: 8'h01, 02, 04, 08, 10, 20, C1, 03, …
- Lock: feed seed-01 words from reset, one per cycle -> locked=1 one cycle after the 9th word (first word sets prev, then 8 matches). err_count=0.
- Single error: after lock, XOR 8'h04 into one word -> err_pulse high for exactly one cycle, err_count=1, locked stays 1. Following clean words give no further pulses.
- Loss of lock: after lock, corrupt 4 words within 16 -> locked falls after the 4th. err_count=4. Clean stream then relocks after LOCK_COUNT matches.
- Zero source: feed constant 8'h00 -> locked stays 0 indefinitely and err_count=0. Also feed 8'h40 (bit7≠bit6) in SEARCH -> match_cnt resets.
- Gaps and clear: toggle in_valid 1/0 while locked -> word_count advances only on valid cycles. Assert clr_counts together with an error word -> counters read 0 and err_pulse=1.
- Reset mid-operation while locked with err_count=5 -> all outputs 0 immediately (asynchronous). The bench then relocks and counts from zero.
